fft32_twiddle_sequencer: RTL and testbench
==========================================

// Module: fft32_twiddle_sequencer
// PURPOSE
//  Twiddle-address scheduler for the 32-point radix-2 DIF MDC FFT.
//  Generates the 4-bit ROM16 address for butterfly stages 1..4 of each frame.
//  Tracks frames in flight through the pipeline and flags protocol errors.
//  Stage 5 uses a trivial twiddle (W=1) and is not sequenced here.
//  Sits between the FFT input control and the per-stage complex multipliers.
// PARAMETERS
//  MAX_FRAMES  4   max frames in flight (pend counter saturates here); range 1..7
// PORTS
//  clk          in   1   system clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  sync_clr     in   1   synchronous clear: same effect as reset, next edge
//  frame_start  in   1   pulse: a new 32-sample frame enters stage 1
//  stage_vld    in   4   [s-1] = stage s butterfly pair valid this cycle
//  tw_addr_s1   out  4   ROM16 address, stage 1
//  tw_addr_s2   out  4   ROM16 address, stage 2
//  tw_addr_s3   out  4   ROM16 address, stage 3
//  tw_addr_s4   out  4   ROM16 address, stage 4
//  tw_vld       out  4   [s-1] = tw_addr_s<s> valid this cycle
//  frame_done   out  1   1-cycle pulse: stage 4 consumed the 16th pair of a frame
//  busy         out  1   1 while pend != 0
//  err_ovr      out  1   sticky: frame_start dropped (pend == MAX_FRAMES)
//  err_orph     out  1   sticky: stage_vld[0] seen while pend == 0 (orphan)
// BEHAVIOUR
//  Reset / sync_clr: all counters, pend, and FSM go to IDLE.
//   All outputs become 0, including the sticky error flags.
//  Per-stage counter cnt_s (4 bits):
//   - increments on stage_vld[s-1]; wraps 15 -> 0 (16 pairs per frame per stage)
//   - holds when its valid is low
//  Address map (one cycle registered latency after stage_vld):
//   - s1: addr = cnt1                   (W32^k, k=0..15)
//   - s2: addr = {cnt2[2:0],1'b0}       (0,2,..,14, repeated twice)
//   - s3: addr = {cnt3[1:0],2'b00}      (0,4,8,12, x4)
//   - s4: addr = {cnt4[0],3'b000}       (0,8, x8)
//  tw_vld[s-1] = stage_vld[s-1] delayed 1 cycle.
//   The datapath delays butterfly data by 1 cycle to align with the ROM output.
//  tw_addr_sX holds its last value when tw_vld is low.
//  pend (3 bits) = frames in flight:
//   - +1 on an accepted frame_start
//   - -1 when cnt4 wraps 15 -> 0
//   - simultaneous +1 and -1: net unchanged
//   - frame_start is accepted only when pend < MAX_FRAMES, or when pend == MAX_FRAMES
//     and a decrement occurs in the same cycle
//   - otherwise frame_start is dropped and err_ovr is set
//  FSM:
//   - IDLE -> RUN on an accepted frame_start
//   - RUN -> IDLE when pend goes 1 -> 0 with no accept that cycle
//   - busy = (state == RUN)
//  Orphan valids:
//   - stage_vld[0] in IDLE (before frame_start is registered): set err_orph; cnt1 does NOT advance
//   - stage_vld[0] in the same cycle as the accepted frame_start: legal, counts as sample 0
//  frame_done is registered and asserts the cycle after the 16th stage_vld[3].
//  Stages 2..4 counters always advance on their valids; no ordering check.
//  Reset mid-frame: immediate clear; the next frame restarts at address 0 in every stage.
// TESTING
//  1 frame_start, then 16 stage_vld[0] back-to-back
//    -> tw_addr_s1 = 0..15 one cycle later, tw_vld[0] high for 16 cycles
//  Stage 2..4 valids, 16 each
//    -> s2 = 0,2,..,14,0,..,14; s3 = 0,4,8,12 x4; s4 = 0,8 x8
//  Gapped stage_vld[1] (1-of-3 duty)
//    -> addresses advance only on valid; held value between valids
//  Pipelined frames
//    -> frame_done pulses once per 16 stage_vld[3]; busy drops only after the last frame
//  MAX_FRAMES+1 frame_start with no stage-4 completion
//    -> last one dropped, err_ovr=1, pend=MAX_FRAMES
//    -> frame_start coincident with a completion is accepted
//  stage_vld[0] in IDLE -> err_orph=1, cnt1 stays 0
//  rst_n low mid-frame at cnt1=7 -> all outputs 0; a new frame starts at address 0

Source files
------------

// File: rtl/fft32_twiddle_sequencer.sv
// fft32_twiddle_sequencer: twiddle ROM16 address scheduler for stages 1..4 of a 32-point radix-2 DIF MDC FFT
// Ports:
//   clk, rst_n         clock (rising edge) and asynchronous active-low reset
//   sync_clr_i         synchronous clear, same effect as reset on the next edge
//   frame_start_i      pulse: a new 32-sample frame enters stage 1
//   stage_vld_i[3:0]   [s-1] = stage s butterfly pair valid this cycle
//   tw_addr_s1..s4_o   registered ROM16 address per stage, held while its valid is low
//   tw_vld_o[3:0]      [s-1] = tw_addr_s<s>_o valid this cycle
//   frame_done_o       1-cycle pulse after stage 4 consumes the 16th pair of a frame
//   busy_o             high while frames are in flight
//   err_ovr_o          sticky: a frame_start was dropped because the pipeline was full
//   err_orph_o         sticky: a stage 1 valid arrived with no frame in flight
module fft32_twiddle_sequencer #(
  parameter int MAX_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sync_clr_i,
  input  logic       frame_start_i,
  input  logic [3:0] stage_vld_i,
  output logic [3:0] tw_addr_s1_o,
  output logic [3:0] tw_addr_s2_o,
  output logic [3:0] tw_addr_s3_o,
  output logic [3:0] tw_addr_s4_o,
  output logic [3:0] tw_vld_o,
  output logic       frame_done_o,
  output logic       busy_o,
  output logic       err_ovr_o,
  output logic       err_orph_o
);
  localparam logic [2:0] MAX = 3'(MAX_FRAMES);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [3:0][3:0] cnt_q, cnt_d, addr_q, addr_d;
  logic [3:0] vld_q, vld_d;
  logic [2:0] pend_q, pend_d;
  logic done_q, ovr_q, ovr_d, orph_q, orph_d;
  logic wrap, dec, accept;
  always_comb begin
    wrap = stage_vld_i[3] && cnt_q[3] == 4'd15;
    // a completion with nothing pending must not underflow the frame count
    dec = wrap && pend_q != 3'd0;
    // a full pipeline still accepts a frame when one retires in the same cycle
    accept = frame_start_i && (pend_q < MAX || dec);
    // stage 1 valids only count once a frame is in flight (or arrives this cycle)
    vld_d = {stage_vld_i[3:1], stage_vld_i[0] && (state_q == RUN || accept)};
    pend_d = pend_q + {2'b0, accept} - {2'b0, dec};
    state_d = state_q == IDLE ? (accept ? RUN : IDLE) : (pend_d == 3'd0 ? IDLE : RUN);
    ovr_d = ovr_q | (frame_start_i & ~accept);
    orph_d = orph_q | (stage_vld_i[0] & ~vld_d[0]);
    // stage s uses W32^(k*2^(s-1)), i.e. the pair count shifted up by s-1 modulo 16
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = vld_d[i] ? cnt_q[i] + 4'd1 : cnt_q[i];
      addr_d[i] = vld_d[i] ? cnt_q[i] << i : addr_q[i];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      vld_q <= '0;
      pend_q <= '0;
      done_q <= 1'b0;
      ovr_q <= 1'b0;
      orph_q <= 1'b0;
    end else if (sync_clr_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      vld_q <= '0;
      pend_q <= '0;
      done_q <= 1'b0;
      ovr_q <= 1'b0;
      orph_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      vld_q <= vld_d;
      pend_q <= pend_d;
      done_q <= wrap;
      ovr_q <= ovr_d;
      orph_q <= orph_d;
    end
  end
  assign tw_addr_s1_o = addr_q[0];
  assign tw_addr_s2_o = addr_q[1];
  assign tw_addr_s3_o = addr_q[2];
  assign tw_addr_s4_o = addr_q[3];
  assign tw_vld_o = vld_q;
  assign frame_done_o = done_q;
  assign busy_o = state_q == RUN;
  assign err_ovr_o = ovr_q;
  assign err_orph_o = orph_q;
endmodule

// File: tb/tb_fft32_twiddle_sequencer.sv
// tb_fft32_twiddle_sequencer: self-checking bench for fft32_twiddle_sequencer
module tb_fft32_twiddle_sequencer;
  localparam int MAXF = 4;
  logic clk = 1'b0, rst_n = 1'b0, sync_clr = 1'b0, frame_start = 1'b0;
  logic [3:0] stage_vld = '0;
  logic [3:0] a1, a2, a3, a4, tv;
  logic done, busy, ovr, orph;
  int n_chk = 0, n_fail = 0;
  int m_cnt[4], m_addr[4], m_pend;
  logic [3:0] m_tv;
  logic m_done, m_ovr, m_orph;
  typedef struct {
    logic fs;
    logic [3:0] v;
    logic [3:0] a1, a2, tv;
    logic busy;
  } vec_t;
  vec_t tbl[8];
  fft32_twiddle_sequencer #(.MAX_FRAMES(MAXF)) dut (
    .clk(clk), .rst_n(rst_n), .sync_clr_i(sync_clr), .frame_start_i(frame_start),
    .stage_vld_i(stage_vld), .tw_addr_s1_o(a1), .tw_addr_s2_o(a2), .tw_addr_s3_o(a3),
    .tw_addr_s4_o(a4), .tw_vld_o(tv), .frame_done_o(done), .busy_o(busy),
    .err_ovr_o(ovr), .err_orph_o(orph)
  );
  always #5 clk = ~clk;
  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction
  function automatic logic [31:0] actual();
    return {8'h0, a1, a2, a3, a4, tv, done, busy, ovr, orph};
  endfunction
  function automatic logic [31:0] expected();
    return {8'h0, 4'(m_addr[0]), 4'(m_addr[1]), 4'(m_addr[2]), 4'(m_addr[3]), m_tv, m_done,
            m_pend > 0, m_ovr, m_orph};
  endfunction
  function automatic void model_reset();
    for (int s = 0; s < 4; s++) begin
      m_cnt[s] = 0;
      m_addr[s] = 0;
    end
    m_pend = 0;
    m_tv = '0;
    m_done = 1'b0;
    m_ovr = 1'b0;
    m_orph = 1'b0;
  endfunction
  // frame-level view: each stage consumes 16 pairs per frame, stage s needs twiddle index k*2^s mod 16
  function automatic void model_step(logic fs, logic [3:0] v);
    logic retire, acc, s1ok;
    retire = v[3] && m_cnt[3] == 15 && m_pend > 0;
    acc = fs && (m_pend < MAXF || retire);
    s1ok = v[0] && (m_pend > 0 || acc);
    m_done = v[3] && m_cnt[3] == 15;
    if (fs && !acc) m_ovr = 1'b1;
    if (v[0] && !s1ok) m_orph = 1'b1;
    m_tv = {v[3:1], s1ok};
    for (int s = 0; s < 4; s++)
      if (m_tv[s]) begin
        m_addr[s] = (m_cnt[s] * (1 << s)) % 16;
        m_cnt[s] = (m_cnt[s] + 1) % 16;
      end
    m_pend = m_pend + int'(acc) - int'(retire);
  endfunction
  task automatic step(input logic fs, input logic [3:0] v, input logic clr = 1'b0);
    frame_start = fs;
    stage_vld = v;
    sync_clr = clr;
    @(posedge clk);
    if (clr) model_reset();
    else model_step(fs, v);
    #1;
    check("cycle", actual(), expected());
    frame_start = 1'b0;
    stage_vld = '0;
    sync_clr = 1'b0;
  endtask
  initial begin
    tbl[0] = '{1'b1, 4'h1, 4'd0, 4'd0, 4'h1, 1'b1};
    tbl[1] = '{1'b0, 4'h1, 4'd1, 4'd0, 4'h1, 1'b1};
    tbl[2] = '{1'b0, 4'h0, 4'd1, 4'd0, 4'h0, 1'b1};
    tbl[3] = '{1'b0, 4'h1, 4'd2, 4'd0, 4'h1, 1'b1};
    tbl[4] = '{1'b0, 4'h2, 4'd2, 4'd0, 4'h2, 1'b1};
    tbl[5] = '{1'b0, 4'h3, 4'd3, 4'd2, 4'h3, 1'b1};
    tbl[6] = '{1'b0, 4'h2, 4'd3, 4'd4, 4'h2, 1'b1};
    tbl[7] = '{1'b0, 4'h0, 4'd3, 4'd4, 4'h0, 1'b1};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset", actual(), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].fs, tbl[i].v);
      check($sformatf("vec%0d", i), {a1, a2, tv, busy}, {tbl[i].a1, tbl[i].a2, tbl[i].tv, tbl[i].busy});
    end
    step(1'b0, 4'h0, 1'b1);
    check("sync_clr", actual(), 32'h0);
    // full frame through stage 1, then stages 2..4 together
    step(1'b1, 4'h1);
    for (int k = 1; k < 16; k++) step(1'b0, 4'h1);
    check("s1_last", a1, 15);
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 4'he);
      check("s2_seq", a2, (2 * k) % 16);
      check("s3_seq", a3, (4 * k) % 16);
      check("s4_seq", a4, (8 * k) % 16);
    end
    check("done_pulse", {done, busy}, 2'b10);
    step(1'b0, 4'h0);
    check("done_clear", done, 1'b0);
    // gapped stage 2 valids: three valids in nine cycles
    for (int k = 0; k < 9; k++) step(1'b0, k % 3 == 0 ? 4'h2 : 4'h0);
    check("s2_gap", a2, 4);
    // overflow and the coincident-completion exception
    step(1'b0, 4'h0, 1'b1);
    for (int k = 0; k < MAXF; k++) step(1'b1, 4'h0);
    check("no_ovr_at_max", ovr, 1'b0);
    for (int k = 0; k < 15; k++) step(1'b0, 4'h8);
    step(1'b1, 4'h8);
    check("accept_on_retire", {ovr, done}, 2'b01);
    step(1'b1, 4'h0);
    check("ovr_drop", ovr, 1'b1);
    for (int k = 0; k < 16 * MAXF; k++) begin
      step(1'b0, 4'h8);
      if (k == 16 * MAXF - 2) check("busy_before_last", busy, 1'b1);
    end
    check("busy_after_last", {busy, ovr}, 2'b01);
    // orphan stage 1 valid while idle
    step(1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h1);
    check("orphan", {orph, tv}, 5'b10000);
    step(1'b1, 4'h1);
    check("orph_cnt_held", {a1, tv[0]}, 5'b00001);
    step(1'b0, 4'h1);
    check("orph_next", a1, 1);
    // asynchronous reset mid-frame at cnt1 = 7
    step(1'b0, 4'h0, 1'b1);
    step(1'b1, 4'h1);
    for (int k = 0; k < 6; k++) step(1'b0, 4'h1);
    check("pre_rst_a1", a1, 6);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst", actual(), 32'h0);
    model_reset();
    #2 rst_n = 1'b1;
    step(1'b1, 4'h1);
    check("restart_a1", {a1, tv}, 8'h01);
    // randomized traffic against the frame-level model
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 15) == 0, 4'($urandom), $urandom_range(0, 499) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
